// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding, counter-width helper and legal SIZE range.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SIZE_MIN = 2;
  localparam int SIZE_MAX = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit size_ok(input int s);
    return (s >= SIZE_MIN) && (s <= SIZE_MAX);
  endfunction

endpackage

// File: rtl/mult_sign_cond.sv
// Conditional two's-complement negate (magnitude / final sign fix).
// Ports: i_val operand, i_neg negate request, o_mag result.
module mult_sign_cond #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_mag
);

  assign o_mag = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 shift-add multiplier, signed/unsigned, valid/ready in and out.
// Ports: clk, reset, in_valid/in_ready, a, b, is_signed,
//   out_valid/out_ready, q. Option: SEQ_MULT_EARLY_TERM_EN.
module seq_mult
  import mult_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] q
);

  localparam int CNT_W = clog2(SIZE);
  localparam int PW    = 2 * SIZE;

  if (!size_ok(SIZE)) begin : g_bad_size
    $error("seq_mult: SIZE out of range");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_q;
  logic [SIZE-1:0]  r_mplier;
  logic             r_sign;
  logic             r_out_valid;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [SIZE-1:0]  w_a_mag;
  logic [SIZE-1:0]  w_b_mag;
  logic [SIZE-1:0]  w_mplier_nxt;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_q_nxt;
  logic             w_last;

  assign w_a_neg = is_signed & a[SIZE-1];
  assign w_b_neg = is_signed & b[SIZE-1];

  mult_sign_cond #(.W(SIZE)) u_mag_a (
    .i_val (a),
    .i_neg (w_a_neg),
    .o_mag (w_a_mag)
  );

  mult_sign_cond #(.W(SIZE)) u_mag_b (
    .i_val (b),
    .i_neg (w_b_neg),
    .o_mag (w_b_mag)
  );

  // Multiplicand is pre-shifted each step, so it
  // always sits at the weight of the current bit.
  assign w_mplier_nxt = r_mplier >> 1;
  assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);

  mult_sign_cond #(.W(PW)) u_neg_q (
    .i_val (w_acc_nxt),
    .i_neg (r_sign),
    .o_mag (w_q_nxt)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Stop once no set multiplier bits remain.
  assign w_last = (r_cnt == CNT_W'(SIZE - 1))
                | (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CNT_W'(SIZE - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_mplier    <= '0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= PW'(w_a_mag);
            r_mplier <= w_b_mag;
            r_sign   <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_q         <= w_q_nxt;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) & ~reset;
  assign out_valid = r_out_valid;
  assign q         = r_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (SIZE=8).
// Expected latency follows SEQ_MULT_EARLY_TERM_EN when defined.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q;

  int n_chk = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  seq_mult #(.SIZE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] vb,
                                 input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [7:0] m;
    int l;
    m = (s && vb[7]) ? 8'(-vb) : vb;
    l = 1;
    for (int i = 0; i < 8; i++)
      if (m[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Counts edges after the accepting edge until out_valid.
  task automatic wait_out(output int l);
    l = 0;
    do begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end while (!out_valid && l < 40);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag,
                       input logic [7:0] ta,
                       input logic [7:0] tb,
                       input logic ts,
                       input logic [15:0] eq,
                       input int hold);
    int l;
    @(negedge clk);
    a = ta;
    b = tb;
    is_signed = ts;
    in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    is_signed = ~ts;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    wait_out(l);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat(tb, ts)));
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_done_rdy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_q"}, 32'(q), 32'(eq));
      check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    handshake(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_rel_rdy", 32'(in_ready), 32'd1);

    do_op("u200x150", 8'd200, 8'd150, 1'b0, 16'h7530, 5);
    do_op("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    do_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    do_op("u_ffsq", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    do_op("s_m1sq", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    do_op("s_7xm2", 8'h07, 8'hFE, 1'b1, 16'hFFF2, 0);

    // Operands presented during RUN must be ignored.
    @(negedge clk);
    a = 8'd200;
    b = 8'd150;
    is_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'd3;
    b = 8'd4;
    wait_out(lat);
    check("ign_lat", 32'(lat), 32'(exp_lat(8'd150, 1'b0)));
    check("ign_q", 32'(q), 32'h7530);
    handshake("ign");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    check("ign2_lat", 32'(lat), 32'(exp_lat(8'd4, 1'b0)));
    check("ign2_q", 32'(q), 32'd12);
    handshake("ign2");

    // Reset three cycles into RUN.
    @(negedge clk);
    a = 8'h55;
    b = 8'h33;
    is_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rel_rdy", 32'(in_ready), 32'd1);
    do_op("u7x9", 8'd7, 8'd9, 1'b0, 16'h003F, 0);

    do_op("u_bzero", 8'h12, 8'h00, 1'b0, 16'h0000, 0);
    do_op("u_3x80", 8'h03, 8'h80, 1'b0, 16'h0180, 0);
    do_op("u_5x3", 8'h05, 8'h03, 1'b0, 16'h000F, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
